// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone arbiter. Round-robin grants happen only between bus cycles, and a watchdog flags an owner that holds the bus too long.
// Optional: define ARB_STATS_EN to add grant and wait statistics counters.
module wb_rr_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb0_cyc,
  input  logic              i_wb0_stb,
  input  logic              i_wb0_we,
  input  logic [ADDR_W-1:0] i_wb0_adr,
  input  logic [DATA_W-1:0] i_wb0_dat,
  input  logic [SEL_W-1:0]  i_wb0_sel,
  input  logic              i_wb0_4_burst,
  input  logic              i_wb0_8_burst,
  output logic              o_wb0_ack,
  output logic              o_wb0_err,
  output logic              o_wb0_rty,
  input  logic              i_wb1_cyc,
  input  logic              i_wb1_stb,
  input  logic              i_wb1_we,
  input  logic [ADDR_W-1:0] i_wb1_adr,
  input  logic [DATA_W-1:0] i_wb1_dat,
  input  logic [SEL_W-1:0]  i_wb1_sel,
  input  logic              i_wb1_4_burst,
  input  logic              i_wb1_8_burst,
  output logic              o_wb1_ack,
  output logic              o_wb1_err,
  output logic              o_wb1_rty,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_dat,
  output logic [SEL_W-1:0]  o_wb_sel,
  output logic              o_wb_4_burst,
  output logic              o_wb_8_burst,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic              i_wb_rty,
`ifdef ARB_STATS_EN
  output logic [15:0]       o_grant_cnt0,
  output logic [15:0]       o_grant_cnt1,
  output logic [15:0]       o_wait_cnt,
`endif
  output logic              o_owner,
  output logic              o_hold_viol
);

  localparam int HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t            state_reg;
  logic              owner_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              hold_viol_reg;

  logic granted0;
  logic granted1;
  logic other_waiting;

  assign granted0      = (state_reg == GRANT0);
  assign granted1      = (state_reg == GRANT1);
  assign other_waiting = (granted0 && i_wb1_cyc) || (granted1 && i_wb0_cyc);

  // Re-arbitration is only possible from IDLE, so a burst can never be split.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b1;
      hold_cnt_reg  <= '0;
      hold_viol_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_wb0_cyc && (!i_wb1_cyc || owner_reg)) begin
            state_reg    <= GRANT0;
            owner_reg    <= 1'b0;
            hold_cnt_reg <= '0;
          end else if (i_wb1_cyc) begin
            state_reg    <= GRANT1;
            owner_reg    <= 1'b1;
            hold_cnt_reg <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if ((granted0 && !i_wb0_cyc) || (granted1 && !i_wb1_cyc)) begin
            state_reg <= TURN;
          end
          if (other_waiting && hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
            if (hold_cnt_reg + 1'b1 == HOLD_MAX) begin
              hold_viol_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_adr     = '0;
    o_wb_dat     = '0;
    o_wb_sel     = '0;
    o_wb_4_burst = 1'b0;
    o_wb_8_burst = 1'b0;
    if (granted0) begin
      o_wb_cyc     = i_wb0_cyc;
      o_wb_stb     = i_wb0_stb;
      o_wb_we      = i_wb0_we;
      o_wb_adr     = i_wb0_adr;
      o_wb_dat     = i_wb0_dat;
      o_wb_sel     = i_wb0_sel;
      o_wb_4_burst = i_wb0_4_burst;
      o_wb_8_burst = i_wb0_8_burst;
    end else if (granted1) begin
      o_wb_cyc     = i_wb1_cyc;
      o_wb_stb     = i_wb1_stb;
      o_wb_we      = i_wb1_we;
      o_wb_adr     = i_wb1_adr;
      o_wb_dat     = i_wb1_dat;
      o_wb_sel     = i_wb1_sel;
      o_wb_4_burst = i_wb1_4_burst;
      o_wb_8_burst = i_wb1_8_burst;
    end
  end

  assign o_wb0_ack   = granted0 && i_wb_ack;
  assign o_wb0_err   = granted0 && i_wb_err;
  assign o_wb0_rty   = granted0 && i_wb_rty;
  assign o_wb1_ack   = granted1 && i_wb_ack;
  assign o_wb1_err   = granted1 && i_wb_err;
  assign o_wb1_rty   = granted1 && i_wb_rty;
  assign o_owner     = owner_reg;
  assign o_hold_viol = hold_viol_reg;

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt0_reg;
  logic [15:0] grant_cnt1_reg;
  logic [15:0] wait_cnt_reg;
  logic        wait0;
  logic        wait1;
  logic        grant0_now;
  logic        grant1_now;

  // A master waits whenever it has cyc high but is not the one on the bus.
  assign wait0      = i_wb0_cyc && !granted0;
  assign wait1      = i_wb1_cyc && !granted1;
  assign grant0_now = (state_reg == IDLE) && i_wb0_cyc && (!i_wb1_cyc || owner_reg);
  assign grant1_now = (state_reg == IDLE) && i_wb1_cyc && !grant0_now;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_cnt0_reg <= '0;
      grant_cnt1_reg <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      if (grant0_now) grant_cnt0_reg <= grant_cnt0_reg + 16'd1;
      if (grant1_now) grant_cnt1_reg <= grant_cnt1_reg + 16'd1;
      wait_cnt_reg <= wait_cnt_reg + 16'(wait0) + 16'(wait1);
    end
  end

  assign o_grant_cnt0 = grant_cnt0_reg;
  assign o_grant_cnt1 = grant_cnt1_reg;
  assign o_wait_cnt   = wait_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a cycle table plus hand sequences for bursts, the watchdog and reset.
module tb_wb_rr_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;
  localparam logic [ADDR_W-1:0] ADR0 = 24'h0000A0;
  localparam logic [ADDR_W-1:0] ADR1 = 24'h0000B1;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_wb0_cyc, i_wb0_stb, i_wb0_we, i_wb0_4_burst, i_wb0_8_burst;
  logic i_wb1_cyc, i_wb1_stb, i_wb1_we, i_wb1_4_burst, i_wb1_8_burst;
  logic [ADDR_W-1:0] i_wb0_adr, i_wb1_adr, o_wb_adr;
  logic [DATA_W-1:0] i_wb0_dat, i_wb1_dat, o_wb_dat;
  logic [SEL_W-1:0]  i_wb0_sel, i_wb1_sel, o_wb_sel;
  logic o_wb0_ack, o_wb0_err, o_wb0_rty, o_wb1_ack, o_wb1_err, o_wb1_rty;
  logic o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst;
  logic i_wb_ack, i_wb_err, i_wb_rty;
  logic o_owner, o_hold_viol;
`ifdef ARB_STATS_EN
  logic [15:0] o_grant_cnt0, o_grant_cnt1, o_wait_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  wb_rr_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb0_cyc(i_wb0_cyc), .i_wb0_stb(i_wb0_stb), .i_wb0_we(i_wb0_we),
    .i_wb0_adr(i_wb0_adr), .i_wb0_dat(i_wb0_dat), .i_wb0_sel(i_wb0_sel),
    .i_wb0_4_burst(i_wb0_4_burst), .i_wb0_8_burst(i_wb0_8_burst),
    .o_wb0_ack(o_wb0_ack), .o_wb0_err(o_wb0_err), .o_wb0_rty(o_wb0_rty),
    .i_wb1_cyc(i_wb1_cyc), .i_wb1_stb(i_wb1_stb), .i_wb1_we(i_wb1_we),
    .i_wb1_adr(i_wb1_adr), .i_wb1_dat(i_wb1_dat), .i_wb1_sel(i_wb1_sel),
    .i_wb1_4_burst(i_wb1_4_burst), .i_wb1_8_burst(i_wb1_8_burst),
    .o_wb1_ack(o_wb1_ack), .o_wb1_err(o_wb1_err), .o_wb1_rty(o_wb1_rty),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_4_burst(o_wb_4_burst), .o_wb_8_burst(o_wb_8_burst),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_rty(i_wb_rty),
`ifdef ARB_STATS_EN
    .o_grant_cnt0(o_grant_cnt0), .o_grant_cnt1(o_grant_cnt1), .o_wait_cnt(o_wait_cnt),
`endif
    .o_owner(o_owner), .o_hold_viol(o_hold_viol)
  );

  typedef struct packed {
    logic              cyc0;
    logic              cyc1;
    logic              ack;
    logic              exp_cyc;
    logic              exp_owner;
    logic              exp_ack0;
    logic              exp_ack1;
    logic [ADDR_W-1:0] exp_adr;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_wb0_cyc = 0; i_wb0_stb = 0; i_wb0_we = 0; i_wb0_4_burst = 0; i_wb0_8_burst = 0;
    i_wb1_cyc = 0; i_wb1_stb = 0; i_wb1_we = 1; i_wb1_4_burst = 0; i_wb1_8_burst = 0;
    i_wb0_adr = ADR0; i_wb0_dat = 16'h1111; i_wb0_sel = 2'b01;
    i_wb1_adr = ADR1; i_wb1_dat = 16'h2222; i_wb1_sel = 2'b10;
    i_wb_ack = 0; i_wb_err = 0; i_wb_rty = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
  endtask

  initial begin
    // Each row is one cycle: inputs driven, then outputs checked mid-cycle.
    //               cyc0 cyc1 ack  cyc  own  a0   a1   adr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ADR0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ADR0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ADR0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ADR1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ADR1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};

    do_reset();
    chk("reset_hold_viol", 32'(o_hold_viol), 32'd0);
    chk("reset_wb0_err", 32'(o_wb0_err), 32'd0);

    for (int r = 0; r < 11; r++) begin
      i_wb0_cyc = vecs[r].cyc0; i_wb0_stb = vecs[r].cyc0;
      i_wb1_cyc = vecs[r].cyc1; i_wb1_stb = vecs[r].cyc1;
      i_wb_ack  = vecs[r].ack;
      #3;
      chk($sformatf("vec%0d_cyc", r), 32'(o_wb_cyc), 32'(vecs[r].exp_cyc));
      chk($sformatf("vec%0d_owner", r), 32'(o_owner), 32'(vecs[r].exp_owner));
      chk($sformatf("vec%0d_ack0", r), 32'(o_wb0_ack), 32'(vecs[r].exp_ack0));
      chk($sformatf("vec%0d_ack1", r), 32'(o_wb1_ack), 32'(vecs[r].exp_ack1));
      chk($sformatf("vec%0d_adr", r), 32'(o_wb_adr), 32'(vecs[r].exp_adr));
      tick();
    end

    // Contested request straight after reset, then round-robin hand-over.
    do_reset();
    i_wb0_cyc = 1; i_wb1_cyc = 1; i_wb1_stb = 1;
    tick();
    #3;
    chk("contest_owner", 32'(o_owner), 32'd0);
    chk("contest_cyc", 32'(o_wb_cyc), 32'd1);
    chk("contest_dat", 32'(o_wb_dat), 32'h1111);
    chk("contest_we", 32'(o_wb_we), 32'd0);
    i_wb_err = 1;
    #1;
    chk("contest_err0", 32'(o_wb0_err), 32'd1);
    chk("contest_err1", 32'(o_wb1_err), 32'd0);
    tick();
    i_wb_err = 0;
    #3;
    chk("err_no_release", 32'(o_wb_cyc), 32'd1);
    i_wb0_cyc = 0;
    tick();
    #3;
    chk("turn_cyc", 32'(o_wb_cyc), 32'd0);
    tick();
    #3;
    chk("idle_cyc", 32'(o_wb_cyc), 32'd0);
    tick();
    #3;
    chk("m1_grant_owner", 32'(o_owner), 32'd1);
    chk("m1_grant_cyc", 32'(o_wb_cyc), 32'd1);
    chk("m1_grant_sel", 32'(o_wb_sel), 32'(2'b10));
    chk("m1_grant_we", 32'(o_wb_we), 32'd1);
    i_wb1_cyc = 0; i_wb1_stb = 0;
    tick(); tick();
    i_wb0_cyc = 1; i_wb1_cyc = 1;
    tick();
    #3;
    chk("rr_again_owner", 32'(o_owner), 32'd0);

    // 8-beat burst by master 1 with master 0 requesting mid-burst.
    do_reset();
    i_wb1_cyc = 1; i_wb1_stb = 1; i_wb1_8_burst = 1;
    tick();
    begin
      int acks1 = 0;
      int acks0 = 0;
      for (int b = 0; b < 8; b++) begin
        i_wb_ack = 1;
        if (b == 2) begin
          i_wb0_cyc = 1; i_wb0_stb = 1;
        end
        #3;
        acks1 += int'(o_wb1_ack);
        acks0 += int'(o_wb0_ack);
        if (b == 5) begin
          chk("burst_owner", 32'(o_owner), 32'd1);
          chk("burst_hint", 32'(o_wb_8_burst), 32'd1);
        end
        tick();
      end
      chk("burst_acks1", 32'(acks1), 32'd8);
      chk("burst_acks0", 32'(acks0), 32'd0);
    end
    i_wb_ack = 0; i_wb1_cyc = 0; i_wb1_stb = 0; i_wb1_8_burst = 0;
    tick();
    #3;
    chk("burst_turn_cyc", 32'(o_wb_cyc), 32'd0);
    tick();
    #3;
    chk("burst_idle_cyc", 32'(o_wb_cyc), 32'd0);
    tick();
    #3;
    chk("burst_next_owner", 32'(o_owner), 32'd0);
    chk("burst_next_adr", 32'(o_wb_adr), 32'(ADR0));

    // Watchdog: master 0 holds while master 1 waits for 40 cycles.
    do_reset();
    i_wb0_cyc = 1;
    tick();
    i_wb1_cyc = 1;
    for (int i = 1; i <= 40; i++) begin
      #3;
      if (i == 32) chk("viol_before", 32'(o_hold_viol), 32'd0);
      if (i == 33) chk("viol_after", 32'(o_hold_viol), 32'd1);
      if (i == 40) begin
        chk("viol_sticky", 32'(o_hold_viol), 32'd1);
        chk("viol_owner", 32'(o_owner), 32'd0);
        chk("viol_cyc", 32'(o_wb_cyc), 32'd1);
      end
      tick();
    end

    // Reset with an ack pending mid-transfer.
    i_wb_ack = 1;
    #3;
    chk("pre_rst_ack0", 32'(o_wb0_ack), 32'd1);
    i_rst = 1;
    tick();
    i_rst = 0;
    #3;
    chk("rst_mid_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_mid_ack0", 32'(o_wb0_ack), 32'd0);
    chk("rst_mid_ack1", 32'(o_wb1_ack), 32'd0);
    chk("rst_mid_owner", 32'(o_owner), 32'd1);
    chk("rst_mid_viol", 32'(o_hold_viol), 32'd0);

`ifdef ARB_STATS_EN
    // Alternating solo grants: each spends one IDLE cycle waiting.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      if (g % 2 == 0) i_wb0_cyc = 1; else i_wb1_cyc = 1;
      tick(); tick();
      i_wb0_cyc = 0; i_wb1_cyc = 0;
      tick(); tick();
    end
    #3;
    chk("stats_grant0", 32'(o_grant_cnt0), 32'd3);
    chk("stats_grant1", 32'(o_grant_cnt1), 32'd2);
    chk("stats_wait", 32'(o_wait_cnt), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Two-master Wishbone arbiter that shares one downstream bus between two requesters, e.g. the data cache and the merged instruction-fetch path, or two instruction caches.
- Arbitration happens only at Wishbone cycle boundaries, with round-robin fairness, so 4/8-beat bursts are never split.
- A hold-time watchdog flags an owner that keeps the bus for too long while the other master waits.
- Sits between the cache masters and the external bus port of the upper core.

Parameters:
ADDR_W, 24, Wishbone address width.
DATA_W, 16, Wishbone data width.
SEL_W, 2, byte-select width.
MAX_HOLD, 32, cycles the owner may hold cyc while the other master waits before a violation is flagged; legal range 2..255.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_wb0_cyc, i_wb0_stb, i_wb0_we  in  1 each  master 0 strobes
i_wb0_adr  in  ADDR_W  master 0 address
i_wb0_dat  in  DATA_W  master 0 write data
i_wb0_sel  in  SEL_W  master 0 byte select
i_wb0_4_burst, i_wb0_8_burst  in  1 each  master 0 burst hints
o_wb0_ack, o_wb0_err, o_wb0_rty  out  1 each  master 0 responses
i_wb1_*  in  (same set and widths as master 0)  master 1 request signals
o_wb1_*  out  (same set and widths as master 0)  master 1 responses
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  downstream strobes
o_wb_adr  out  ADDR_W  downstream address
o_wb_dat  out  DATA_W  downstream write data
o_wb_sel  out  SEL_W  downstream byte select
o_wb_4_burst, o_wb_8_burst  out  1 each  downstream burst hints
i_wb_ack, i_wb_err, i_wb_rty  in  1 each  downstream responses
o_owner  out  1  current or last grant: 0 = master 0, 1 = master 1
o_hold_viol  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Clocking and reset: single clock i_clk; i_rst is synchronous, active-high.
- Reset values:
  - state IDLE, o_owner=1, so master 0 wins the first contested arbitration.
  - hold counter 0, o_hold_viol=0.
  - all o_wb_* and all master response outputs 0.
- IDLE:
  - Downstream outputs all 0.
  - If exactly one i_wbN_cyc is high, go to GRANTN.
  - If both are high, grant the master != o_owner.
  - o_owner updates on the same edge as the state transition.
  - Grant latency: 1 cycle from cyc rising to o_wb_cyc.
- GRANT0 / GRANT1:
  - o_wb_cyc/stb/we/adr/dat/sel/4_burst/8_burst are a combinational mux of the owner's inputs.
  - i_wb_ack/err/rty go to the owner only; the non-owner's responses are held 0.
- Release: when the owner drops cyc, go to TURN for exactly one cycle with o_wb_cyc=0, then IDLE. A new grant therefore needs at least 2 cycles after release.
- Non-owner stb without cyc is ignored.
- err/rty: forwarded to the owner only. The arbiter does not release on err; release happens only on the owner's cyc drop.
- Hold watchdog:
  - Counter clears on every grant.
  - Increments each GRANT cycle in which the non-owner has cyc high; saturates at MAX_HOLD.
  - Reaching MAX_HOLD sets o_hold_viol. The grant is not revoked.
- Reset mid-transfer: on the next edge, return to IDLE with all outputs 0. Pending acks are dropped.
- A master that reasserts cyc in the cycle right after TURN competes normally; round-robin prevents back-to-back wins when both request.

Optional Feature:
ARB_STATS_EN
- With the macro: adds outputs o_grant_cnt0 and o_grant_cnt1 (16 bits each) and o_wait_cnt (16 bits).
  - Each grant counter increments on every grant to its master.
  - o_wait_cnt increments on every cycle a master has cyc high while not owner.
  - All three wrap at 16'hFFFF→0 and reset to 0.
- Without the macro: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then i_wb0_cyc=1 alone → o_wb_cyc=1 one cycle later, o_owner=0; acks reach o_wb0_ack only, o_wb1_ack stays 0.
- Both cyc rise in the same cycle after reset → master 0 granted. After master 0 releases, exactly 1 TURN cycle with o_wb_cyc=0, then master 1 granted (o_owner=1).
- Master 1 runs an 8-beat burst (8_burst=1) while master 0 requests mid-burst → all 8 acks go to master 1, no mid-burst switch; master 0 is granted 2 cycles after master 1 drops cyc.
- Master 0 holds cyc for 40 cycles while master 1 waits, MAX_HOLD=32 → o_hold_viol=1 after the 32nd waiting cycle; the grant stays with master 0.
- i_rst asserted mid-transfer with ack pending → next cycle o_wb_cyc=0, all responses 0, o_owner=1, o_hold_viol=0.
- ARB_STATS_EN: 3 grants to master 0 and 2 to master 1 → o_grant_cnt0=3, o_grant_cnt1=2; o_wait_cnt equals the sum of waiting cycles.
